// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output stream in, natural bin order out.
// Optional FFT_REORDER_SOP_EN adds osop, high alongside the bin-0 output word.
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 11
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

module fft_bitrev_reorder #(
  parameter int FFT_STG = 7,
  parameter int SIM_DLY = 1
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     ien,
  input  logic [`TOTAL_STAGE-1:0]  iaddr,
  input  logic [`CPLX_WIDTH-1:0]   idata,
  output logic                     oen,
  output logic [`TOTAL_STAGE-1:0]  oaddr,
  output logic [`CPLX_WIDTH-1:0]   odata,
  output logic                     oovf
`ifdef FFT_REORDER_SOP_EN
  ,
  output logic                     osop
`endif
);

  localparam int unsigned AW  = FFT_STG;
  localparam int unsigned N   = 1 << FFT_STG;
  localparam int unsigned AWO = `TOTAL_STAGE;
  localparam int unsigned CW  = `CPLX_WIDTH;

  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  logic [CW-1:0] mem [2*N];
  logic [1:0]    bank_full;
  logic          wbank, rbank;
  logic [AW-1:0] wcnt, wslot, rptr, rd_ptr;
  logic          wr_acc, wr_last, rd_start, rd_last, rd_vld;
  logic [CW-1:0] rd_data;
  rd_state_t     rd_state;

  // Upper iaddr bits are ignored; SIM_DLY is kept only for instantiation compatibility.
  logic unused_ok;
  assign unused_ok = ^{iaddr, 32'(SIM_DLY)};

  always_comb begin
    wslot = '0;
    for (int unsigned i = 0; i < AW; i++) wslot[i] = iaddr[AW-1-i];
  end

  assign wr_acc  = ien & ~bank_full[wbank];
  assign wr_last = wr_acc && (wcnt == '1);
  // The reader also sees a bank that is completing this cycle, so it starts one cycle earlier.
  assign rd_start = (rd_state == RD_IDLE) &&
                    (bank_full[rbank] || (wr_last && (wbank == rbank)));
  assign rd_last  = (rd_state == RD_READ) && (rptr == '1);

  always_ff @(posedge iclk) begin
    if (irst) begin
      bank_full <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wcnt      <= '0;
      oovf      <= 1'b0;
      rd_state  <= RD_IDLE;
      rptr      <= '0;
    end else begin
      if (wr_acc) begin
        wcnt <= wcnt + 1'b1;
        if (wr_last) wbank <= ~wbank;
      end
      if (ien && bank_full[wbank]) oovf <= 1'b1;
      if (wr_last) bank_full[wbank] <= 1'b1;
      if (rd_last) bank_full[rbank] <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (rd_start) begin
            rd_state <= RD_READ;
            rptr     <= '0;
          end
        end
        RD_READ: begin
          rptr <= rptr + 1'b1;
          if (rd_last) begin
            rd_state <= RD_IDLE;
            rbank    <= ~rbank;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (wr_acc) mem[{wbank, wslot}] <= idata;
    if (rd_state == RD_READ) rd_data <= mem[{rbank, rptr}];
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      rd_vld <= 1'b0;
      rd_ptr <= '0;
      oen    <= 1'b0;
      oaddr  <= '0;
      odata  <= '0;
    end else begin
      rd_vld <= (rd_state == RD_READ);
      if (rd_state == RD_READ) rd_ptr <= rptr;
      oen <= rd_vld;
      if (rd_vld) begin
        oaddr <= AWO'(rd_ptr);
        odata <= rd_data;
      end
    end
  end

`ifdef FFT_REORDER_SOP_EN
  always_ff @(posedge iclk) begin
    if (irst) osop <= 1'b0;
    else      osop <= rd_vld && (rd_ptr == '0);
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (FFT_STG=3) with a frame-level reference model.
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 11
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

module tb_fft_bitrev_reorder;
  localparam int STG = 3;
  localparam int N   = 8;
  localparam int AWO = `TOTAL_STAGE;
  localparam int CW  = `CPLX_WIDTH;

  logic           iclk = 1'b0;
  logic           irst = 1'b1;
  logic           ien  = 1'b0;
  logic [AWO-1:0] iaddr = '0;
  logic [CW-1:0]  idata = '0;
  logic           oen;
  logic [AWO-1:0] oaddr;
  logic [CW-1:0]  odata;
  logic           oovf;
`ifdef FFT_REORDER_SOP_EN
  logic           osop;
`endif

  fft_bitrev_reorder #(.FFT_STG(STG), .SIM_DLY(1)) dut (
    .iclk (iclk),
    .irst (irst),
    .ien  (ien),
    .iaddr(iaddr),
    .idata(idata),
    .oen  (oen),
    .oaddr(oaddr),
    .odata(odata),
    .oovf (oovf)
`ifdef FFT_REORDER_SOP_EN
    ,
    .osop (osop)
`endif
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_on = 0;

  typedef struct {
    int            cyc;
    int            addr;
    logic [CW-1:0] data;
  } exp_t;

  exp_t          expq[$];
  logic [CW-1:0] slot[2][N];
  int            m_wb, m_wcnt, m_last_e;
  int            m_busy[2];
  bit            m_ovf;

  function automatic int bitrev(int k);
    int r = 0;
    for (int i = 0; i < STG; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic model_reset();
    m_wb = 0; m_wcnt = 0; m_busy[0] = -1; m_busy[1] = -1; m_last_e = -10; m_ovf = 0;
  endtask

  // A bank is free once its frame's last read address has been issued; a frame's
  // reads start the cycle after completion or two cycles after the previous frame's last read.
  task automatic model_word(int c, int a, logic [CW-1:0] d);
    int   s;
    exp_t e;
    if (c <= m_busy[m_wb]) begin
      m_ovf = 1;
      return;
    end
    slot[m_wb][bitrev(a)] = d;
    m_wcnt++;
    if (m_wcnt == N) begin
      s = (c + 1 > m_last_e + 2) ? c + 1 : m_last_e + 2;
      m_last_e = s + N - 1;
      m_busy[m_wb] = m_last_e;
      for (int p = 0; p < N; p++) begin
        e.cyc = s + 2 + p; e.addr = p; e.data = slot[m_wb][p];
        expq.push_back(e);
      end
      m_wcnt = 0;
      m_wb ^= 1;
    end
  endtask

  task automatic step(bit rst, bit en, int a, logic [CW-1:0] d);
    @(posedge iclk);
    #1;
    irst  = rst;
    ien   = en;
    iaddr = AWO'(a) | (AWO'($urandom) << STG);
    idata = d;
    if (rst) begin
      while (expq.size() > 0 && expq[$].cyc > cyc) void'(expq.pop_back());
      model_reset();
    end else if (en) begin
      model_word(cyc, a, d);
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, '0);
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(bit shuffle, bit ramp, int maxgap);
    int perm[N];
    int j, t;
    for (int i = 0; i < N; i++) perm[i] = i;
    if (shuffle) begin
      for (int i = N - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
      step(0, 1, perm[i], ramp ? CW'(perm[i] * 16) : CW'($urandom));
    end
  endtask

  task automatic drain();
    int k = 0;
    while (expq.size() > 0 && k < 200) begin
      step(0, 0, 0, '0);
      k++;
    end
    idle(2);
    n_cmp++;
    assert (expq.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout observed=%0d_pending expected=0", expq.size());
    end
  endtask

  always @(negedge iclk) begin
    bit   exp_en;
    exp_t e;
    if (mon_on) begin
      exp_en = (expq.size() > 0) && (expq[0].cyc == cyc);
      n_cmp++;
      assert (oen === exp_en) else begin
        n_err++;
        $error("FAIL oen cyc=%0d observed=%b expected=%b", cyc, oen, exp_en);
      end
      if (exp_en) begin
        e = expq.pop_front();
        n_cmp++;
        assert (oaddr === AWO'(e.addr)) else begin
          n_err++;
          $error("FAIL oaddr cyc=%0d observed=%0d expected=%0d", cyc, oaddr, e.addr);
        end
        n_cmp++;
        assert (odata === e.data) else begin
          n_err++;
          $error("FAIL odata cyc=%0d observed=%0h expected=%0h", cyc, odata, e.data);
        end
      end
`ifdef FFT_REORDER_SOP_EN
      n_cmp++;
      assert (osop === (exp_en && e.addr == 0)) else begin
        n_err++;
        $error("FAIL osop cyc=%0d observed=%b expected=%b", cyc, osop, exp_en && e.addr == 0);
      end
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    @(negedge iclk);
    chk("rst_oen", 64'(oen), 64'd0);
    chk("rst_oaddr", 64'(oaddr), 64'd0);
    chk("rst_odata", 64'(odata), 64'd0);
    chk("rst_oovf", 64'(oovf), 64'd0);
    mon_on = 1;

    // Single ramp frame: bin k carries bitrev(k)*16, first word at T+3.
    send_frame(0, 1, 0);
    drain();
    chk("ramp_oovf", 64'(oovf), 64'd0);

    // Three back-to-back frames at one word per clock.
    send_frame(1, 0, 0);
    send_frame(1, 0, 0);
    send_frame(1, 0, 0);
    drain();
    chk("b2b_oovf", 64'(oovf), 64'd0);

    // Random bubbles inside a frame.
    send_frame(0, 1, 3);
    drain();
    send_frame(1, 0, 3);
    drain();

    // Continuous stream until the writer catches a still-full bank.
    send_frame(1, 0, 0);
    send_frame(1, 0, 0);
    send_frame(1, 0, 0);
    send_frame(1, 0, 0);
    idle(1);
    @(negedge iclk);
    chk("ovf_model", 64'(m_ovf), 64'd1);
    chk("ovf_set", 64'(oovf), 64'(m_ovf));
    drain();
    chk("ovf_sticky", 64'(oovf), 64'd1);

    // Reset after five words of a frame.
    for (int i = 0; i < 5; i++) step(0, 1, i, CW'($urandom));
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    @(negedge iclk);
    chk("rst_mid_wr_oen", 64'(oen), 64'd0);
    chk("rst_mid_wr_oovf", 64'(oovf), 64'd0);

    // Reset while a frame is streaming out.
    send_frame(1, 0, 0);
    idle(5);
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    @(negedge iclk);
    chk("rst_mid_rd_oen", 64'(oen), 64'd0);
    chk("rst_mid_rd_oovf", 64'(oovf), 64'd0);
    send_frame(0, 1, 0);
    drain();

    // Duplicate address: slot for bin bitrev(7) keeps its old contents.
    for (int i = 0; i < N; i++) step(0, 1, (i == N - 1) ? 6 : i, CW'($urandom));
    drain();
    chk("final_oovf", 64'(oovf), 64'd0);

    mon_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
